edge_event_pulse_queue: RTL

//  Multi-channel, single-clock event conditioner for async inputs such as pins and

---
 rtl/edge_event_pulse_queue_if.sv | 16 +
 rtl/edge_event_pulse_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/edge_event_pulse_queue_if.sv
// Event conditioner port bundle: raw async inputs and per-channel controls in,
// conditioned pulses, pending counts and overflow flags out.
interface edge_event_pulse_queue_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0]       A;
    logic [2*WIDTH-1:0]     mode;
    logic [WIDTH-1:0]       clr;
    logic [WIDTH-1:0]       Y;
    logic [WIDTH*CNT_W-1:0] pend;
    logic [WIDTH-1:0]       ovf;

    modport master (output A, mode, clr, input Y, pend, ovf);
    modport slave  (input A, mode, clr, output Y, pend, ovf);
endinterface

// File: rtl/edge_event_pulse_queue.sv
// Per-channel sync -> debounce -> edge detect -> saturating event queue -> spaced 1-cycle pulses.
// Latency A->Y is SYNC_STAGES+FILTER_LEN+2 edges; no backpressure, events beyond the queue depth set sticky ovf.
module edge_event_pulse_queue #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 4,
    parameter int GAP         = 0,
    parameter bit DEFAULT_VAL = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    edge_event_pulse_queue_if.slave bus
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [FW-1:0]    FLAST    = FW'(FILTER_LEN - 1);
    localparam logic [GW-1:0]    GLOAD    = GW'(GAP);

    typedef enum logic {S_IDLE, S_GAP} sched_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        logic                   stable;
        logic                   stable_d;
        logic [FW-1:0]          fcnt;
        logic                   evt;
        logic                   issue;
        logic [CNT_W-1:0]       pend;
        logic                   ovf;
        logic                   y;
        sched_t                 state;
        logic [GW-1:0]          gcnt;

        assign s = sync[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                sync     <= {SYNC_STAGES{DEFAULT_VAL}};
                stable   <= DEFAULT_VAL;
                stable_d <= DEFAULT_VAL;
                fcnt     <= '0;
            end else begin
                sync     <= {sync[SYNC_STAGES-2:0], bus.A[i]};
                stable_d <= stable;
                // A new level must be seen FILTER_LEN cycles in a row before it is accepted.
                if (s == stable) begin
                    fcnt <= '0;
                end else if (fcnt == FLAST) begin
                    stable <= s;
                    fcnt   <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end

        always_comb begin
            evt = 1'b0;
            case (bus.mode[2*i +: 2])
                2'b00:   evt = stable & ~stable_d;
                2'b01:   evt = ~stable & stable_d;
                2'b10:   evt = stable ^ stable_d;
                default: evt = 1'b0;
            endcase
        end

        assign issue = (state == S_IDLE) && (pend != '0) && !bus.clr[i];

        always_ff @(posedge clk) begin
            if (rst || bus.clr[i]) begin
                pend <= '0;
                ovf  <= 1'b0;
            end else if (evt && issue) begin
                pend <= pend;
            end else if (evt) begin
                if (pend != PEND_MAX) pend <= pend + CNT_W'(1);
                else                  ovf  <= 1'b1;
            end else if (issue) begin
                pend <= pend - CNT_W'(1);
            end
        end

        // gcnt counts down the forced idle cycles; IDLE is re-entered as it passes 1 so the pulse period is GAP+1.
        always_ff @(posedge clk) begin
            if (rst || bus.clr[i]) begin
                state <= S_IDLE;
                gcnt  <= '0;
                y     <= 1'b0;
            end else begin
                y <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (issue) begin
                            y <= 1'b1;
                            if (GAP > 0) begin
                                state <= S_GAP;
                                gcnt  <= GLOAD;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gcnt <= GW'(1)) state <= S_IDLE;
                        else                gcnt  <= gcnt - GW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end

        assign bus.Y[i]                 = y;
        assign bus.pend[i*CNT_W +: CNT_W] = pend;
        assign bus.ovf[i]               = ovf;
    end
endmodule
